// File: rtl/beep_seq_defs_pkg.sv
// Shared definitions for the beeper sequencer: state encoding, note word
// field layout, marker values and a counter width helper.
package beep_seq_defs;

  // 3-bit state encoding, explicit so the values are stable across tools.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_PLAY  = 3'd3,
    ST_GAP   = 3'd4,
    ST_END   = 3'd5
  } state_t;

  // Note word layout: [15:12] beats, [11:0] tone code.
  localparam int BEATS_MSB = 15;
  localparam int BEATS_LSB = 12;
  localparam int CODE_MSB  = 11;

  localparam logic [3:0]  END_BEATS = 4'd0;   // beats value marking end of song
  localparam logic [11:0] REST_CODE = 12'd0;  // tone code meaning silence

  // Bits needed to hold the values 0..n-1 (never less than one bit).
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/beep_seq_timer.sv
// Loadable down-counter with a zero flag. Used for the tick, beat and gap
// counts of the beeper sequencer. Clear has priority over load, and the
// counter parks at zero instead of wrapping.
module beep_seq_timer #(
  parameter int W = 8
) (
  input  logic         sclk,
  input  logic         nrst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  // Count register: clear, load, or decrement towards zero.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of block evaluation order.
  always_ff @(posedge sclk or negedge nrst) begin
    if (!nrst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/beep_seq_ctrl.sv
// Beeper note sequencer: walks the note ROM from address 0, fetches one
// word per step, sounds each note for beats*BEAT_CYCLES cycles, inserts a
// GAP_CYCLES silence after each note and ends on a zero-beats marker or
// after SONG_LEN entries. stop aborts playback from any busy state.
// Build option: define BEEP_SEQ_LOOP_EN to replay the song until stop
// instead of returning to idle with a done pulse.
module beep_seq_ctrl
  import beep_seq_defs::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BEAT_FREQ  = 4,
  parameter int GAP_CYCLES = 2_500_000,
  parameter int SONG_LEN   = 64
) (
  input  logic        sclk,
  input  logic        nrst,
  input  logic        start,
  input  logic        stop,
  output logic [15:0] rom_addr,
  input  logic [15:0] rom_data,
  output logic [11:0] tone_code,
  output logic        tone_en,
  output logic        busy,
  output logic        done
);

  localparam int BEAT_CYCLES = (CLK_FREQ / BEAT_FREQ < 1) ? 1 : CLK_FREQ / BEAT_FREQ;
  localparam bit HAS_GAP     = (GAP_CYCLES > 0);
  localparam int TICK_W      = cnt_width(BEAT_CYCLES);
  localparam int GAP_W       = cnt_width(HAS_GAP ? GAP_CYCLES : 1);
  localparam logic [TICK_W-1:0] TICK_RELOAD = TICK_W'(BEAT_CYCLES - 1);
  localparam logic [GAP_W-1:0]  GAP_RELOAD  = GAP_W'(HAS_GAP ? GAP_CYCLES - 1 : 0);
  localparam logic [15:0]       LAST_ADDR   = 16'(SONG_LEN - 1);

`ifdef BEEP_SEQ_LOOP_EN
  localparam bit LOOP_EN = 1'b1;
`else
  localparam bit LOOP_EN = 1'b0;
`endif

  state_t      state;
  logic [3:0]  beats;
  logic [11:0] code;

  assign beats = rom_data[BEATS_MSB:BEATS_LSB];
  assign code  = rom_data[CODE_MSB:0];

  logic tick_zero, beat_zero, gap_zero;
  logic tick_load, tick_dec, beat_load, beat_dec, gap_load, gap_dec;
  logic abort, note_last, advance, to_end;

  assign abort = stop && (state != ST_IDLE);

  // Counter control and step decisions derived from state and zero flags.
  // NOTE: every signal gets a default before the case so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    tick_load = 1'b0;
    tick_dec  = 1'b0;
    beat_load = 1'b0;
    beat_dec  = 1'b0;
    gap_load  = 1'b0;
    gap_dec   = 1'b0;
    note_last = 1'b0;
    case (state)
      ST_WAIT: begin
        if (beats != END_BEATS) begin
          tick_load = 1'b1;
          beat_load = 1'b1;
        end
      end
      ST_PLAY: begin
        if (!tick_zero) begin
          tick_dec = 1'b1;
        end else if (!beat_zero) begin
          tick_load = 1'b1;
          beat_dec  = 1'b1;
        end else begin
          note_last = 1'b1;
          gap_load  = HAS_GAP;
        end
      end
      ST_GAP:  gap_dec = 1'b1;
      default: ;
    endcase
    advance = (note_last && !HAS_GAP) || ((state == ST_GAP) && gap_zero);
    to_end  = (advance && (rom_addr == LAST_ADDR)) ||
              ((state == ST_WAIT) && (beats == END_BEATS));
  end

  beep_seq_timer #(.W(TICK_W)) u_tick (
    .sclk(sclk), .nrst(nrst), .clr(abort), .load(tick_load),
    .load_val(TICK_RELOAD), .dec(tick_dec), .zero(tick_zero)
  );

  beep_seq_timer #(.W(4)) u_beat (
    .sclk(sclk), .nrst(nrst), .clr(abort), .load(beat_load),
    .load_val(beats - 4'd1), .dec(beat_dec), .zero(beat_zero)
  );

  beep_seq_timer #(.W(GAP_W)) u_gap (
    .sclk(sclk), .nrst(nrst), .clr(abort), .load(gap_load),
    .load_val(GAP_RELOAD), .dec(gap_dec), .zero(gap_zero)
  );

  // Sequencer FSM with registered outputs; abort and end-of-song first.
  always_ff @(posedge sclk or negedge nrst) begin
    if (!nrst) begin
      state     <= ST_IDLE;
      rom_addr  <= '0;
      tone_code <= '0;
      tone_en   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else if (abort) begin
      state     <= ST_IDLE;
      rom_addr  <= '0;
      tone_code <= '0;
      tone_en   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else if (to_end) begin
      state     <= ST_END;
      rom_addr  <= '0;
      tone_code <= '0;
      tone_en   <= 1'b0;
      done      <= !LOOP_EN;
    end else if (advance) begin
      state     <= ST_FETCH;
      rom_addr  <= rom_addr + 16'd1;
      tone_en   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          rom_addr <= '0;
          if (start && !stop) begin
            state <= ST_FETCH;
            busy  <= 1'b1;
          end
        end
        ST_FETCH: state <= ST_WAIT;
        ST_WAIT: begin
          tone_code <= code;
          tone_en   <= (code != REST_CODE);
          state     <= ST_PLAY;
        end
        ST_PLAY: begin
          if (note_last) begin
            tone_en <= 1'b0;
            state   <= ST_GAP;
          end
        end
        ST_GAP: ;
        ST_END: begin
          done <= 1'b0;
          if (LOOP_EN) begin
            state <= ST_FETCH;
          end else begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_beep_seq_ctrl.sv
// Self-checking bench for beep_seq_ctrl with a 4-entry synchronous ROM.
// The reference model expands the ROM contents into the expected per-cycle
// output trace directly from the note/gap/end rules.
module tb_beep_seq_ctrl;

  localparam int CLK_FREQ   = 4;
  localparam int BEAT_FREQ  = 1;
  localparam int GAP_CYCLES = 3;
  localparam int SONG_LEN   = 4;
  localparam int BEAT_CYC   = CLK_FREQ / BEAT_FREQ;

  logic        sclk = 1'b0;
  logic        nrst = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [15:0] rom_addr;
  logic [15:0] rom_data = '0;
  logic [11:0] tone_code;
  logic        tone_en;
  logic        busy;
  logic        done;

  beep_seq_ctrl #(
    .CLK_FREQ(CLK_FREQ), .BEAT_FREQ(BEAT_FREQ),
    .GAP_CYCLES(GAP_CYCLES), .SONG_LEN(SONG_LEN)
  ) dut (
    .sclk(sclk), .nrst(nrst), .start(start), .stop(stop),
    .rom_addr(rom_addr), .rom_data(rom_data), .tone_code(tone_code),
    .tone_en(tone_en), .busy(busy), .done(done)
  );

  always #5 sclk = ~sclk;

  // ROM model with one cycle of read latency plus an address bound monitor.
  logic [15:0] rom_mem [SONG_LEN];
  int addr_err = 0;
  always @(posedge sclk) begin
    rom_data <= rom_mem[rom_addr[1:0]];
    if (rom_addr >= 16'(SONG_LEN)) addr_err <= addr_err + 1;
  end

  typedef struct packed {
    logic        busy;
    logic        en;
    logic [11:0] code;
    logic [15:0] addr;
    logic        done;
  } obs_t;

  obs_t exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic obs_t mk(input logic b, input logic e, input logic [11:0] c,
                              input int a, input logic d);
    obs_t o;
    o.busy = b; o.en = e; o.code = c; o.addr = 16'(a); o.done = d;
    return o;
  endfunction

  function automatic obs_t sample();
    return mk(busy, tone_en, tone_code, int'(rom_addr), done);
  endfunction

  // Expected trace, one entry per clock edge starting at the start edge.
  task automatic build_model();
    logic [15:0] w;
    logic [11:0] prev, c;
    int bt, passes;
    bit loop_en;
`ifdef BEEP_SEQ_LOOP_EN
    loop_en = 1'b1; passes = 2;
`else
    loop_en = 1'b0; passes = 1;
`endif
    exp_q.delete();
    for (int p = 0; p < passes; p++) begin
      prev = '0;
      for (int a = 0; a < SONG_LEN; a++) begin
        w = rom_mem[a];
        exp_q.push_back(mk(1, 0, prev, a, 0));       // fetch
        exp_q.push_back(mk(1, 0, prev, a, 0));       // wait
        bt = int'(w[15:12]);
        if (bt == 0) break;
        c = w[11:0];
        for (int k = 0; k < bt * BEAT_CYC; k++) exp_q.push_back(mk(1, c != 0, c, a, 0));
        for (int k = 0; k < GAP_CYCLES; k++) exp_q.push_back(mk(1, 0, c, a, 0));
        prev = c;
      end
      exp_q.push_back(mk(1, 0, 12'h0, 0, !loop_en));  // end
    end
    exp_q.push_back(mk(0, 0, 12'h0, 0, 0));           // idle afterwards
  endtask

  // Play the loaded song; stop_at = -1 none, -2 random, else entry index.
  task automatic run_song(input int stop_at_in, input bit rand_start,
                          output int busy_cyc, output int tone_cyc, output int done_cnt);
    int n, stop_at;
    bit stop_pend;
    obs_t e;
    build_model();
    n = exp_q.size();
    stop_at = stop_at_in;
    if (stop_at == -2) stop_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, n - 3)) : -1;
`ifdef BEEP_SEQ_LOOP_EN
    if (stop_at < 0) stop_at = n - 2;
`endif
    busy_cyc = 0; tone_cyc = 0; done_cnt = 0;
    stop_pend = 1'b0;
    start = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge sclk); #1;
      e = stop_pend ? obs_t'(0) : exp_q[i];
      check($sformatf("trace[%0d]", i), 64'(sample()), 64'(e));
      busy_cyc += int'(busy); tone_cyc += int'(tone_en); done_cnt += int'(done);
      if (stop_pend) break;
      start = (rand_start && i < n - 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (i == stop_at) begin stop = 1'b1; stop_pend = 1'b1; end
    end
    start = 1'b0; stop = 1'b0;
    @(posedge sclk); #1;
  endtask

  typedef struct packed {
    logic [3:0][15:0] w;
    int exp_busy;
    int exp_tone;
    int exp_done;
  } vec_t;

  vec_t tv[5];
  int bc, tc, dc;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tv[0] = '{w: {16'h0000, 16'h3456, 16'h1000, 16'h2123}, exp_busy: 42, exp_tone: 20, exp_done: 1};
    tv[1] = '{w: {16'h1004, 16'h1003, 16'h1002, 16'h1001}, exp_busy: 37, exp_tone: 16, exp_done: 1};
    tv[2] = '{w: {16'h1111, 16'h1111, 16'h1111, 16'h0000}, exp_busy: 3,  exp_tone: 0,  exp_done: 1};
    tv[3] = '{w: {16'h1111, 16'h1111, 16'h0000, 16'h1000}, exp_busy: 12, exp_tone: 0,  exp_done: 1};
    tv[4] = '{w: {16'h1111, 16'h1111, 16'h0000, 16'hF001}, exp_busy: 68, exp_tone: 60, exp_done: 1};

    // Reset state.
    for (int j = 0; j < SONG_LEN; j++) rom_mem[j] = tv[0].w[j];
    #23;
    check("reset_outputs", 64'(sample()), 64'(0));
    @(negedge sclk); nrst = 1'b1;
    @(posedge sclk); #1;
    check("idle_after_reset", 64'(sample()), 64'(0));

    // start and stop together in idle: stop wins.
    start = 1'b1; stop = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge sclk); #1;
      check("start_stop_idle", 64'(sample()), 64'(0));
    end
    start = 1'b0; stop = 1'b0;
    @(posedge sclk); #1;

`ifndef BEEP_SEQ_LOOP_EN
    // Table of songs: full trace plus hand-derived totals.
    for (int k = 0; k < 5; k++) begin
      for (int j = 0; j < SONG_LEN; j++) rom_mem[j] = tv[k].w[j];
      run_song(-1, (k == 1), bc, tc, dc);
      check($sformatf("busy_cycles[%0d]", k), 64'(bc), 64'(tv[k].exp_busy));
      check($sformatf("tone_cycles[%0d]", k), 64'(tc), 64'(tv[k].exp_tone));
      check($sformatf("done_pulses[%0d]", k), 64'(dc), 64'(tv[k].exp_done));
    end
`else
    // Loop build: two passes with no done, then stop.
    for (int j = 0; j < SONG_LEN; j++) rom_mem[j] = tv[0].w[j];
    run_song(-1, 1'b1, bc, tc, dc);
    check("loop_done_never", 64'(dc), 64'(0));
    check("loop_tone_cycles", 64'(tc), 64'(40));
`endif

    // stop in the middle of the 0x456 note (entry 28 lies in its play window).
    for (int j = 0; j < SONG_LEN; j++) rom_mem[j] = tv[0].w[j];
    run_song(28, 1'b0, bc, tc, dc);
    for (int i = 0; i < 3; i++) begin
      @(posedge sclk); #1;
      dc += int'(done);
    end
    check("stop_no_done", 64'(dc), 64'(0));

    // Async reset in the gap after the first note, then replay from address 0.
    start = 1'b1;
    @(posedge sclk); #1;
    start = 1'b0;
    for (int i = 0; i < 11; i++) @(posedge sclk);
    #1;
    check("in_gap", 64'(sample()), 64'(mk(1, 0, 12'h123, 0, 0)));
    #2 nrst = 1'b0;
    #1;
    check("async_reset_outputs", 64'(sample()), 64'(0));
    repeat (2) @(negedge sclk);
    nrst = 1'b1;
    @(posedge sclk); #1;
    run_song(-1, 1'b0, bc, tc, dc);

    // Randomized songs with random start noise and occasional stop.
    for (int r = 0; r < 8; r++) begin
      for (int j = 0; j < SONG_LEN; j++) begin
        rom_mem[j][15:12] = ($urandom_range(0, 4) == 0) ? 4'd0 : 4'($urandom_range(1, 3));
        rom_mem[j][11:0]  = ($urandom_range(0, 3) == 0) ? 12'd0 : 12'($urandom_range(1, 4095));
      end
      run_song(-2, 1'b1, bc, tc, dc);
    end

    check("addr_bound", 64'(addr_err), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
